// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller: 8 lines x 32 bytes in an external SRAM,
// backed by an external SDRAM. Tag/valid/dirty state lives here, one register set per line.
module cache_ctrl #(
    parameter int SD_RD_LAT  = 2,
    parameter int NUM_LINES  = 8,
    parameter int LINE_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        wr_rd,
    input  logic [15:0] Address,
    input  logic [7:0]  DIn,
    output logic [7:0]  DOut,
    output logic        rdy,
    output logic [7:0]  sram_addr,
    output logic [7:0]  sram_din,
    input  logic [7:0]  sram_dout,
    output logic        sram_we,
    output logic [15:0] sd_addr,
    output logic [7:0]  sd_dout,
    input  logic [7:0]  sd_din,
    output logic        sd_mstrb,
    output logic        sd_wr_rd
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int TAG_W = 16 - IDX_W - OFF_W;
    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);
    localparam logic [2:0]       LAT      = 3'(SD_RD_LAT);

    typedef enum logic [3:0] {
        S_IDLE,
        S_COMPARE,
        S_WR,
        S_RD,
        S_RDCAP,
        S_WB_A,
        S_WB_B,
        S_FILL_ISSUE,
        S_FILL_WAIT
    } state_t;

    state_t            r_state;
    logic              r_cs_q;
    logic [TAG_W-1:0]  r_tag;
    logic [IDX_W-1:0]  r_idx;
    logic [OFF_W-1:0]  r_off;
    logic              r_wr;
    logic [7:0]        r_din;
    logic [OFF_W-1:0]  r_cnt;
    logic [2:0]        r_lat;

    logic [7:0]        r_dout;
    logic              r_rdy;
    logic [7:0]        r_sram_addr;
    logic [7:0]        r_sram_din;
    logic              r_sram_we;
    logic [15:0]       r_sd_addr;
    logic [7:0]        r_sd_dout;
    logic              r_sd_mstrb;
    logic              r_sd_wr_rd;

    logic [NUM_LINES-1:0] w_valid;
    logic [NUM_LINES-1:0] w_dirty;
    logic [TAG_W-1:0]     w_tags [NUM_LINES];

    logic             w_req;
    logic             w_hit;
    logic             w_wr_done;
    logic             w_wb_done;
    logic             w_fill_capture;
    logic             w_fill_done;
    logic [OFF_W-1:0] w_cnt_inc;

    assign w_req          = cs & ~r_cs_q;
    assign w_hit          = w_valid[r_idx] && (w_tags[r_idx] == r_tag);
    assign w_cnt_inc      = r_cnt + OFF_W'(1);
    assign w_wr_done      = (r_state == S_WR);
    assign w_wb_done      = (r_state == S_WB_B) && (r_cnt == CNT_LAST);
    assign w_fill_capture = (r_state == S_FILL_WAIT) && (r_lat == LAT);
    assign w_fill_done    = w_fill_capture && (r_cnt == CNT_LAST);

    // Per-line bookkeeping; only the line selected by the latched index ever changes.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
            logic             r_line_valid;
            logic             r_line_dirty;
            logic [TAG_W-1:0] r_line_tag;
            logic             w_sel;

            assign w_sel       = (r_idx == IDX_W'(gi));
            assign w_valid[gi] = r_line_valid;
            assign w_dirty[gi] = r_line_dirty;
            assign w_tags[gi]  = r_line_tag;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_line_valid <= 1'b0;
                    r_line_dirty <= 1'b0;
                    r_line_tag   <= '0;
                end else if (w_sel) begin
                    if (w_fill_done) begin
                        r_line_tag   <= r_tag;
                        r_line_valid <= 1'b1;
                        r_line_dirty <= 1'b0;
                    end else if (w_wb_done) begin
                        r_line_dirty <= 1'b0;
                    end else if (w_wr_done) begin
                        r_line_dirty <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cs_q      <= 1'b0;
            r_tag       <= '0;
            r_idx       <= '0;
            r_off       <= '0;
            r_wr        <= 1'b0;
            r_din       <= '0;
            r_cnt       <= '0;
            r_lat       <= '0;
            r_dout      <= '0;
            r_rdy       <= 1'b1;
            r_sram_addr <= '0;
            r_sram_din  <= '0;
            r_sram_we   <= 1'b0;
            r_sd_addr   <= '0;
            r_sd_dout   <= '0;
            r_sd_mstrb  <= 1'b0;
            r_sd_wr_rd  <= 1'b0;
        end else begin
            r_cs_q     <= cs;
            r_sram_we  <= 1'b0;
            r_sd_mstrb <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_tag   <= Address[15:IDX_W+OFF_W];
                        r_idx   <= Address[IDX_W+OFF_W-1:OFF_W];
                        r_off   <= Address[OFF_W-1:0];
                        r_wr    <= wr_rd;
                        r_din   <= DIn;
                        r_rdy   <= 1'b0;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    r_cnt <= '0;
                    if (w_hit) begin
                        r_sram_addr <= {r_idx, r_off};
                        if (r_wr) begin
                            r_sram_we  <= 1'b1;
                            r_sram_din <= r_din;
                            r_state    <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end else if (w_valid[r_idx] && w_dirty[r_idx]) begin
                        r_sram_addr <= {r_idx, {OFF_W{1'b0}}};
                        r_state     <= S_WB_A;
                    end else begin
                        r_state <= S_FILL_ISSUE;
                    end
                end
                S_WR: begin
                    r_rdy   <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_RD: begin
                    r_state <= S_RDCAP;
                end
                S_RDCAP: begin
                    r_dout  <= sram_dout;
                    r_rdy   <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_WB_A: begin
                    r_state <= S_WB_B;
                end
                // The SRAM byte addressed in WB_A is on sram_dout now; ship it and
                // point the SRAM at the next byte so every word costs two cycles.
                S_WB_B: begin
                    r_sd_mstrb <= 1'b1;
                    r_sd_wr_rd <= 1'b1;
                    r_sd_addr  <= {w_tags[r_idx], r_idx, r_cnt};
                    r_sd_dout  <= sram_dout;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FILL_ISSUE;
                    end else begin
                        r_cnt       <= w_cnt_inc;
                        r_sram_addr <= {r_idx, w_cnt_inc};
                        r_state     <= S_WB_A;
                    end
                end
                S_FILL_ISSUE: begin
                    r_sd_mstrb <= 1'b1;
                    r_sd_wr_rd <= 1'b0;
                    r_sd_addr  <= {r_tag, r_idx, r_cnt};
                    r_lat      <= '0;
                    r_state    <= S_FILL_WAIT;
                end
                // sd_din is valid in the SD_RD_LAT-th cycle after the strobe cycle; the
                // edge that captures it also issues the next read, giving LAT+1 cycles/word.
                S_FILL_WAIT: begin
                    if (w_fill_capture) begin
                        r_sram_we   <= 1'b1;
                        r_sram_addr <= {r_idx, r_cnt};
                        r_sram_din  <= sd_din;
                        r_lat       <= '0;
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_COMPARE;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            r_sd_mstrb <= 1'b1;
                            r_sd_wr_rd <= 1'b0;
                            r_sd_addr  <= {r_tag, r_idx, w_cnt_inc};
                        end
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign DOut      = r_dout;
    assign rdy       = r_rdy;
    assign sram_addr = r_sram_addr;
    assign sram_din  = r_sram_din;
    assign sram_we   = r_sram_we;
    assign sd_addr   = r_sd_addr;
    assign sd_dout   = r_sd_dout;
    assign sd_mstrb  = r_sd_mstrb;
    assign sd_wr_rd  = r_sd_wr_rd;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: SRAM/SDRAM device models plus a line-level cache model that
// predicts every SDRAM and SRAM transaction, read data and hit latencies.
module tb_cache_ctrl;

    localparam int LAT    = 2;
    localparam int BUDGET = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        wr_rd;
    logic [15:0] Address;
    logic [7:0]  DIn;
    logic [7:0]  DOut;
    logic        rdy;
    logic [7:0]  sram_addr;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout;
    logic        sram_we;
    logic [15:0] sd_addr;
    logic [7:0]  sd_dout;
    logic [7:0]  sd_din;
    logic        sd_mstrb;
    logic        sd_wr_rd;

    cache_ctrl #(.SD_RD_LAT(LAT), .NUM_LINES(8), .LINE_WORDS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .wr_rd     (wr_rd),
        .Address   (Address),
        .DIn       (DIn),
        .DOut      (DOut),
        .rdy       (rdy),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .sram_we   (sram_we),
        .sd_addr   (sd_addr),
        .sd_dout   (sd_dout),
        .sd_din    (sd_din),
        .sd_mstrb  (sd_mstrb),
        .sd_wr_rd  (sd_wr_rd)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // ---------------- device models ----------------
    logic [7:0]  sram_mem [256];
    logic [7:0]  sd_mem   [65536];
    int          pend = 0;
    logic [15:0] pend_addr = '0;

    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_addr] <= sram_din;
        sram_dout <= sram_mem[sram_addr];
    end

    // Read data is valid only in the LAT-th cycle after the strobe cycle; noise otherwise.
    always @(posedge clk) begin
        sd_din <= 8'($urandom);
        if (pend == 1) sd_din <= sd_mem[pend_addr];
        if (pend > 0) pend <= pend - 1;
        if (sd_mstrb) begin
            if (sd_wr_rd) begin
                sd_mem[sd_addr] <= sd_dout;
            end else if (LAT == 1) begin
                sd_din <= sd_mem[sd_addr];
            end else begin
                pend      <= LAT - 1;
                pend_addr <= sd_addr;
            end
        end
    end

    // ---------------- cache model ----------------
    typedef struct packed {logic wr; logic [15:0] addr; logic [7:0] data;} sd_txn_t;
    typedef struct packed {logic [7:0] addr; logic [7:0] data;} sram_txn_t;

    sd_txn_t   exp_sd   [$];
    sram_txn_t exp_sram [$];
    logic [7:0] ref_sd  [65536];
    logic [7:0] m_line  [256];
    logic       m_valid [8];
    logic       m_dirty [8];
    logic [7:0] m_tag   [8];

    int n_checks = 0;
    int n_fail   = 0;
    int n_sd_rd  = 0;
    int n_sd_wr  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 8'h00;
        end
        exp_sd.delete();
        exp_sram.delete();
    endfunction

    // Predicts the full transaction stream of one CPU access and returns read data.
    function automatic logic [7:0] model_req(input logic w, input logic [15:0] a, input logic [7:0] d);
        logic [2:0]  idx = a[7:5];
        logic [7:0]  tag = a[15:8];
        logic [15:0] sa;
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int k = 0; k < 32; k++) begin
                    sa = {m_tag[idx], idx, 5'(k)};
                    exp_sd.push_back('{1'b1, sa, m_line[{idx, 5'(k)}]});
                    ref_sd[sa] = m_line[{idx, 5'(k)}];
                end
            end
            for (int k = 0; k < 32; k++) begin
                sa = {tag, idx, 5'(k)};
                exp_sd.push_back('{1'b0, sa, 8'h00});
                exp_sram.push_back('{{idx, 5'(k)}, ref_sd[sa]});
                m_line[{idx, 5'(k)}] = ref_sd[sa];
            end
            m_tag[idx]   = tag;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (w) begin
            exp_sram.push_back('{a[7:0], d});
            m_line[a[7:0]] = d;
            m_dirty[idx]   = 1'b1;
        end
        return m_line[a[7:0]];
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin : monitor
        sd_txn_t   se;
        sram_txn_t me;
        if (rst !== 1'b1) begin
            if (sd_mstrb) begin
                if (sd_wr_rd) n_sd_wr++;
                else n_sd_rd++;
                check("sd_strobe_expected", 32'(exp_sd.size() > 0), 32'd1);
                if (exp_sd.size() > 0) begin
                    se = exp_sd.pop_front();
                    check("sd_wr_rd", 32'(sd_wr_rd), 32'(se.wr));
                    check("sd_addr", 32'(sd_addr), 32'(se.addr));
                    if (se.wr) check("sd_dout", 32'(sd_dout), 32'(se.data));
                end
            end
            if (sram_we) begin
                check("sram_we_expected", 32'(exp_sram.size() > 0), 32'd1);
                if (exp_sram.size() > 0) begin
                    me = exp_sram.pop_front();
                    check("sram_addr", 32'(sram_addr), 32'(me.addr));
                    check("sram_din", 32'(sram_din), 32'(me.data));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic access(input logic w, input logic [15:0] a, input logic [7:0] d,
                          input int exp_lat, input int hold);
        logic [7:0] exp_dout;
        int lat;
        exp_dout = model_req(w, a, d);
        Address = a;
        wr_rd   = w;
        DIn     = d;
        cs      = 1'b1;
        @(posedge clk); #1;
        check("rdy_low_after_accept", 32'(rdy), 32'd0);
        if (hold <= 1) cs = 1'b0;
        lat = 0;
        while (!rdy && lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
            if (lat >= hold - 1) cs = 1'b0;
        end
        check("rdy_within_budget", 32'(lat < BUDGET), 32'd1);
        for (int k = lat; k < hold - 1; k++) begin
            @(posedge clk); #1;
            check("rdy_held_no_retrigger", 32'(rdy), 32'd1);
        end
        cs = 1'b0;
        if (exp_lat > 0) check("rdy_latency", 32'(lat), 32'(exp_lat));
        check("sd_txns_outstanding", 32'(exp_sd.size()), 32'd0);
        check("sram_writes_outstanding", 32'(exp_sram.size()), 32'd0);
        if (!w) check("dout", 32'(DOut), 32'(exp_dout));
        $display("access %s addr=0x%04h din=0x%02h dout=0x%02h latency=%0d",
                 w ? "WR" : "RD", a, d, DOut, lat);
        @(posedge clk); #1;
    endtask

    int rd0, wr0, target, guard;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sd_mem[i] = pat(16'(i));
            ref_sd[i] = pat(16'(i));
        end
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 8'h00;
            m_line[i]   = 8'h00;
        end
        model_reset();
        rst = 1'b1; cs = 1'b0; wr_rd = 1'b0; Address = '0; DIn = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdy", 32'(rdy), 32'd1);
        check("reset_dout", 32'(DOut), 32'd0);
        check("reset_sram_we", 32'(sram_we), 32'd0);
        check("reset_sd_mstrb", 32'(sd_mstrb), 32'd0);
        check("reset_sd_wr_rd", 32'(sd_wr_rd), 32'd0);
        check("reset_sd_addr", 32'(sd_addr), 32'd0);
        check("reset_sram_addr", 32'(sram_addr), 32'd0);
        check("reset_outputs_data", 32'({sram_din, sd_dout}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        rd0 = n_sd_rd; wr0 = n_sd_wr;
        access(1'b0, 16'h1100, 8'h00, -1, 1);
        check("cold_fill_reads", 32'(n_sd_rd - rd0), 32'd32);
        check("cold_fill_writes", 32'(n_sd_wr - wr0), 32'd0);
        check("dout_1100_literal", 32'(DOut), 32'h2D);

        access(1'b0, 16'h1105, 8'h00, 3, 1);
        check("dout_1105_literal", 32'(DOut), 32'h28);

        access(1'b1, 16'h1100, 8'hAA, 2, 1);
        check("dout_held_after_write", 32'(DOut), 32'h28);

        rd0 = n_sd_rd; wr0 = n_sd_wr;
        access(1'b0, 16'h3300, 8'h00, -1, 1);
        check("wb_writes", 32'(n_sd_wr - wr0), 32'd32);
        check("wb_fill_reads", 32'(n_sd_rd - rd0), 32'd32);
        check("sdram_1100_written_back", 32'(sd_mem[16'h1100]), 32'hAA);
        check("dout_3300_literal", 32'(DOut), 32'h0F);

        access(1'b1, 16'h7721, 8'h5C, -1, 1);
        access(1'b1, 16'h7722, 8'h66, 2, 4);
        access(1'b0, 16'h7722, 8'h00, 3, 1);
        check("dout_7722_literal", 32'(DOut), 32'h66);
        access(1'b0, 16'h7721, 8'h00, 3, 1);
        check("dout_7721_literal", 32'(DOut), 32'h5C);

        // Abort a cold fill at word 10 with reset.
        rd0 = n_sd_rd;
        void'(model_req(1'b0, 16'h5540, 8'h00));
        Address = 16'h5540; wr_rd = 1'b0; cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0;
        target = rd0 + 11;
        guard  = 0;
        while (n_sd_rd < target && guard < BUDGET) begin
            @(posedge clk); #1;
            guard++;
        end
        check("fill_reached_word10", 32'(n_sd_rd), 32'(target));
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check("abort_sd_mstrb", 32'(sd_mstrb), 32'd0);
        check("abort_sram_we", 32'(sram_we), 32'd0);
        check("abort_rdy", 32'(rdy), 32'd1);
        rst = 1'b0;
        $display("access RST mid-fill addr=0x5540 after %0d reads", n_sd_rd - rd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_quiet_rdy", 32'(rdy), 32'd1);

        rd0 = n_sd_rd; wr0 = n_sd_wr;
        access(1'b0, 16'h5540, 8'h00, -1, 1);
        check("refill_reads", 32'(n_sd_rd - rd0), 32'd32);
        check("dout_5540_literal", 32'(DOut), 32'h29);

        // Dirty line 1 was invalidated by reset: refetched without write-back.
        rd0 = n_sd_rd; wr0 = n_sd_wr;
        access(1'b0, 16'h7721, 8'h00, -1, 1);
        check("post_reset_no_wb", 32'(n_sd_wr - wr0), 32'd0);
        check("dout_7721_after_reset", 32'(DOut), 32'h6A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
